// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU-to-memory path.
//   state_t : arbiter FSM states (IDLE, ACCESS, DONE)
//   grant_t : requester identity (FETCH, DATA)
//   DEF_AW / DEF_DW : default address / data widths
//   CNT_W   : width of the access wait counter (WAIT_CYC up to 15)
package cpu_mem_pkg;

    localparam int unsigned DEF_AW = 16;
    localparam int unsigned DEF_DW = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between the
// instruction-fetch stage and the load/store stage.
// Ports:
//   clk, rst                          clock, async active-high reset
//   if_req, if_addr                   fetch request / address
//   if_ack, if_rdata                  fetch completion pulse / fetched word
//   d_req, d_we, d_addr, d_wdata      data request, store flag, address, store data
//   d_ack, d_rdata                    data completion pulse / load result
//   mem_en, mem_we, mem_addr,         memory port (driven only during ACCESS;
//   mem_wdata, mem_rdata              address/wdata hold otherwise)
//   busy                              high whenever the FSM is not in IDLE
// Every output is a register; each one is computed from the next-state
// logic so that it lines up with the state it belongs to.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned WAIT_CYC = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t             state, state_n;
    grant_t             last_grant, last_grant_n;
    grant_t             cur_grant, cur_grant_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [AW-1:0]      mem_addr_n;
    logic [DW-1:0]      mem_wdata_n;
    logic [DW-1:0]      if_rdata_n, d_rdata_n;
    logic               mem_en_n, mem_we_n;
    logic               if_ack_n, d_ack_n, busy_n;
    logic               pick_data;

    // Data wins when alone, or in a contest when fetch was granted last.
    assign pick_data = d_req && (!if_req || (last_grant == FETCH));

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        cur_grant_n  = cur_grant;
        cnt_n        = cnt;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        if_rdata_n   = if_rdata;
        d_rdata_n    = d_rdata;
        mem_en_n     = 1'b0;
        mem_we_n     = 1'b0;
        if_ack_n     = 1'b0;
        d_ack_n      = 1'b0;

        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    state_n  = ACCESS;
                    cnt_n    = CNT_W'(WAIT_CYC - 1);
                    mem_en_n = 1'b1;
                    if (pick_data) begin
                        cur_grant_n = DATA;
                        mem_addr_n  = d_addr;
                        mem_wdata_n = d_wdata;
                        mem_we_n    = d_we;
                    end else begin
                        cur_grant_n = FETCH;
                        mem_addr_n  = if_addr;
                    end
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    // Final access cycle: memory data is valid now.
                    state_n = DONE;
                    if (cur_grant == FETCH) begin
                        if_rdata_n = mem_rdata;
                        if_ack_n   = 1'b1;
                    end else begin
                        if (!mem_we) begin
                            d_rdata_n = mem_rdata;
                        end
                        d_ack_n = 1'b1;
                    end
                end else begin
                    cnt_n    = cnt - CNT_W'(1);
                    mem_en_n = 1'b1;
                    mem_we_n = mem_we;
                end
            end
            DONE: begin
                // Separating cycle: a request still high here is not re-seen.
                state_n      = IDLE;
                last_grant_n = cur_grant;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= FETCH;
            cur_grant  <= FETCH;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            cur_grant  <= cur_grant_n;
            cnt        <= cnt_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            if_rdata   <= if_rdata_n;
            d_rdata    <= d_rdata_n;
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            if_ack     <= if_ack_n;
            d_ack      <= d_ack_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (WAIT_CYC=2 main instance, plus a
// WAIT_CYC=1 instance for the short-latency corner).
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, mem_en, mem_we, busy;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        w1_if_req;
    logic [15:0] w1_if_addr;
    logic        w1_if_ack, w1_d_ack, w1_mem_en, w1_mem_we, w1_busy;
    logic [15:0] w1_if_rdata, w1_d_rdata, w1_mem_addr, w1_mem_wdata;
    logic [15:0] w1_mem_rdata;

    logic [15:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.AW(16), .DW(16), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(16), .DW(16), .WAIT_CYC(1)) dut_w1 (
        .clk(clk), .rst(rst),
        .if_req(w1_if_req), .if_addr(w1_if_addr), .if_ack(w1_if_ack),
        .if_rdata(w1_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_ack(w1_d_ack), .d_rdata(w1_d_rdata),
        .mem_en(w1_mem_en), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr),
        .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata), .busy(w1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple single-port memory model for the main instance.
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    end

    assign w1_mem_rdata = 16'hBEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs [4];
    logic [15:0] exp_if, exp_d;

    // One complete transfer starting in IDLE at the current cycle (cycle 0).
    task automatic run_txn(input int idx, input vec_t v);
        string p;
        p = $sformatf("txn%0d", idx);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        chk({p, " busy c0"}, 32'(busy), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            step();
            chk($sformatf("%s mem_en c%0d", p, c), 32'(mem_en), 32'd1);
            chk($sformatf("%s mem_we c%0d", p, c), 32'(mem_we), 32'(v.is_d & v.we));
            chk($sformatf("%s mem_addr c%0d", p, c), 32'(mem_addr), 32'(v.addr));
            if (v.is_d && v.we)
                chk($sformatf("%s mem_wdata c%0d", p, c), 32'(mem_wdata), 32'(v.wdata));
            chk($sformatf("%s acks c%0d", p, c), 32'({if_ack, d_ack}), 32'd0);
        end
        step();
        if (v.is_d) begin
            if (!v.we) exp_d = v.rdata;
            chk({p, " ack c3"}, 32'({if_ack, d_ack}), 32'b01);
        end else begin
            exp_if = v.rdata;
            chk({p, " ack c3"}, 32'({if_ack, d_ack}), 32'b10);
        end
        chk({p, " mem_en c3"}, 32'(mem_en), 32'd0);
        chk({p, " if_rdata"}, 32'(if_rdata), 32'(exp_if));
        chk({p, " d_rdata"}, 32'(d_rdata), 32'(exp_d));
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        chk({p, " acks c4"}, 32'({if_ack, d_ack}), 32'd0);
        chk({p, " busy c4"}, 32'(busy), 32'd0);
        chk({p, " mem_addr hold"}, 32'(mem_addr), 32'(v.addr));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h010] = 16'hABCD;
        mem[10'h020] = 16'h5A5A;
        if_req = 1'b0; if_addr = 16'h0000;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        w1_if_req = 1'b0; w1_if_addr = 16'h0000;
        exp_if = 16'h0000; exp_d = 16'h0000;

        vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'hABCD};
        vecs[1] = '{is_d: 1'b1, we: 1'b1, addr: 16'h0200, wdata: 16'h1234, rdata: 16'h0000};
        vecs[2] = '{is_d: 1'b1, we: 1'b0, addr: 16'h0200, wdata: 16'h0000, rdata: 16'h1234};
        vecs[3] = '{is_d: 1'b0, we: 1'b0, addr: 16'h0020, wdata: 16'h0000, rdata: 16'h5A5A};

        // Reset state (asynchronous: checked before any clock edge).
        rst = 1'b1;
        #1;
        chk("rst state", 32'({if_ack, d_ack, mem_en, mem_we, busy}), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst rdata", 32'({if_rdata, d_rdata}), 32'd0);
        step();
        rst = 1'b0;

        // Table-driven single transfers.
        for (int i = 0; i < 4; i++) run_txn(i, vecs[i]);

        // Contention after reset and continuous alternation.
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk($sformatf("alt d_ack c%0d", c), 32'(d_ack), 32'((c == 3) || (c == 11)));
            chk($sformatf("alt if_ack c%0d", c), 32'(if_ack), 32'((c == 7) || (c == 15)));
            chk($sformatf("alt mem_en c%0d", c), 32'(mem_en), 32'(((c % 4) == 1) || ((c % 4) == 2)));
            if (c == 3) chk("alt d_rdata", 32'(d_rdata), 32'h1234);
            if (c == 7) chk("alt if_rdata", 32'(if_rdata), 32'hABCD);
        end
        if_req = 1'b0; d_req = 1'b0;

        // Reset in the middle of a load.
        rst = 1'b1;
        step();
        rst = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        step();
        step();
        chk("mid mem_en before rst", 32'(mem_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst mem_en/busy", 32'({mem_en, busy}), 32'd0);
        chk("mid rst d_ack", 32'(d_ack), 32'd0);
        step();
        chk("mid rst held d_ack", 32'({d_ack, busy}), 32'd0);
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("reissue d_ack c%0d", c), 32'(d_ack), 32'(c == 3));
        end
        chk("reissue d_rdata", 32'(d_rdata), 32'h5A5A);
        d_req = 1'b0;
        step();

        // WAIT_CYC=1 corner.
        w1_if_req = 1'b1; w1_if_addr = 16'h0040;
        step();
        chk("w1 mem_en c1", 32'(w1_mem_en), 32'd1);
        chk("w1 mem_addr c1", 32'(w1_mem_addr), 32'h0040);
        chk("w1 if_ack c1", 32'(w1_if_ack), 32'd0);
        step();
        chk("w1 mem_en c2", 32'(w1_mem_en), 32'd0);
        chk("w1 if_ack c2", 32'(w1_if_ack), 32'd1);
        chk("w1 if_rdata", 32'(w1_if_rdata), 32'hBEEF);
        w1_if_req = 1'b0;
        step();
        chk("w1 if_ack c3", 32'({w1_if_ack, w1_busy}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Both acks may never be high together.
    always @(negedge clk) begin
        if (!rst && if_ack && d_ack) begin
            n_tests++;
            n_fail++;
            $display("FAIL dual ack: got if_ack=1 d_ack=1, expected at most one");
        end
    end

endmodule
